i_raster_scan_ctrl: RTL and testbench
=====================================

// Module: i_raster_scan_ctrl
// PURPOSE
//  Sequences a full-frame raster scan of an image held in external pixel memory.
//  - Column and row indices run in raster order: column fastest, then row.
//  - Issues one memory read request per pixel over a req/ack handshake.
//  - Reports each accepted pixel with its (row, col) tag, plus line-end and frame-done events.
//  - Sits between the top-level control FSM and the pixel memory interface; all image-indexing
//    datapaths take their pixel coordinates from it.
// PARAMETERS
//  DIM_W   13  width of img_width/img_height and of the col/row indices (max dimension 8191)
//  ADDR_W  26  width of base_addr and mem_addr (2*DIM_W: covers 8191*8191 pixels)
// PORTS
//  clk          in   1       system clock, rising edge
//  n_rst        in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse: begin a frame scan (accepted only in IDLE)
//  abort        in   1       terminate the scan immediately
//  img_width    in   DIM_W   pixels per line, sampled on accepted start
//  img_height   in   DIM_W   lines per frame, sampled on accepted start
//  base_addr    in   ADDR_W  memory address of pixel (0,0), sampled on accepted start
//  mem_req      out  1       read request
//  mem_addr     out  ADDR_W  address of the pixel currently requested
//  mem_ack      in   1       memory accepted the request this cycle
//  pix_valid    out  1       1-cycle pulse: a pixel was accepted
//  pix_col      out  DIM_W   column of the accepted pixel (qualified by pix_valid)
//  pix_row      out  DIM_W   row of the accepted pixel (qualified by pix_valid)
//  line_end     out  1       with pix_valid: the accepted pixel is the last of its line
//  frame_done   out  1       1-cycle pulse: the last pixel of the frame was accepted
//  busy         out  1       high whenever the state is not IDLE
//  cfg_err      out  1       1-cycle pulse: start was issued with a zero width or height
// BEHAVIOUR
//  Reset: all outputs are 0, state is IDLE, internal col/row/addr and latched config are 0.
//  States:
//   IDLE -> SCAN  on start with width != 0 and height != 0.
//                 Latch the config; col = 0, row = 0, addr = base_addr.
//   IDLE -> IDLE  on start with a zero dimension; cfg_err pulses 1 cycle later.
//   SCAN -> SCAN  on ack of a pixel that is not the last one; advance the indices.
//   SCAN -> DONE  on ack of the last pixel (col == W-1 and row == H-1).
//   DONE -> IDLE  unconditionally after 1 cycle; frame_done is high during DONE.
//  Handshake:
//   - mem_req = 1 exactly while in SCAN; mem_req = 0 in IDLE and DONE.
//   - mem_addr is held stable while mem_req = 1 and mem_ack = 0.
//   - mem_ack is ignored when mem_req = 0.
//   - Holding mem_ack high gives 1 pixel per cycle with no bubbles between pixels or lines.
//  Advance on ack:
//   - col == W-1: col <= 0 and row <= row + 1; otherwise col <= col + 1.
//   - addr <= addr + 1 in both cases: the frame is contiguous, so no multiplier is needed.
//   - Address arithmetic wraps modulo 2^ADDR_W.
//  Output latency:
//   - pix_valid, pix_col, pix_row and line_end are registered and appear 1 cycle after the ack.
//   - pix_col/pix_row hold their last values when pix_valid = 0.
//   - frame_done occurs in the same cycle as the final pix_valid.
//  start while busy: ignored. Latched config is unaffected by input changes mid-scan.
//  abort: any state -> IDLE on the next edge. mem_req drops that edge; no frame_done.
//   - An ack coinciding with abort is discarded: no pix_valid.
//   - abort and start in the same cycle: abort wins (stay IDLE).
//  W = 1 or H = 1: legal. Every pixel of a W = 1 scan asserts line_end.
//  n_rst asserted mid-scan: immediate return to the reset values; no partial pulses.
// TESTING
//  1. W=3, H=2, base=0x100, ack always 1 -> addr 0x100..0x105 on consecutive cycles;
//     (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
//     line_end on (0,2) and (1,2); frame_done with (1,2); busy low 1 cycle later.
//  2. W=4, H=1, ack stalls 3 cycles on pixel 1 -> mem_addr stays base+1 during the stall;
//     exactly 4 pix_valid pulses; no duplicated or skipped coordinates.
//  3. start with W=0, H=5 -> cfg_err pulse; busy stays 0; mem_req never asserts.
//  4. W=10, H=10, abort after 17 acks -> mem_req low the next cycle; 17 pix_valid total;
//     no frame_done; a new start then restarts at (0,0) with addr = base.
//  5. Second start mid-scan with different dims -> ignored; the original frame completes
//     with its latched W/H.
//  6. W=H=8191, base=0 (long run) -> last mem_addr = 67092480; frame_done after
//     67108864 - 16383 = 67092481 acks.
//     Also: n_rst pulsed mid-scan -> all outputs 0 immediately.

Source files
------------

// File: rtl/i_raster_scan_ctrl_if.sv
// i_raster_scan_ctrl_if: pixel memory read request/acknowledge channel
interface i_raster_scan_ctrl_if #(
    parameter int ADDR_W = 26
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    modport master (output mem_req, output mem_addr, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_ack);
endinterface

// File: rtl/i_raster_scan_ctrl.sv
// i_raster_scan_ctrl: raster-order pixel read sequencer with req/ack memory handshake
module i_raster_scan_ctrl #(
    parameter int DIM_W  = 13,
    parameter int ADDR_W = 26
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIM_W-1:0]     img_width,
    input  logic [DIM_W-1:0]     img_height,
    input  logic [ADDR_W-1:0]    base_addr,
    i_raster_scan_ctrl_if.master mem,
    output logic                 pix_valid,
    output logic [DIM_W-1:0]     pix_col,
    output logic [DIM_W-1:0]     pix_row,
    output logic                 line_end,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 cfg_err
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t              state;
    logic [DIM_W-1:0]    col, row, w, h;
    logic [ADDR_W-1:0]   addr;
    logic                req;
    logic                last_col, last_row;
    assign last_col     = col == w - DIM_W'(1);
    assign last_row     = row == h - DIM_W'(1);
    assign mem.mem_req  = req;
    assign mem.mem_addr = addr;
    // The frame is contiguous in memory, so the address simply increments per pixel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            w          <= '0;
            h          <= '0;
            addr       <= '0;
            req        <= 1'b0;
            busy       <= 1'b0;
            pix_valid  <= 1'b0;
            pix_col    <= '0;
            pix_row    <= '0;
            line_end   <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            line_end   <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            if (abort) begin
                state <= IDLE;
                req   <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        if (img_width != '0 && img_height != '0) begin
                            state <= SCAN;
                            w     <= img_width;
                            h     <= img_height;
                            col   <= '0;
                            row   <= '0;
                            addr  <= base_addr;
                            req   <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                    SCAN: if (mem.mem_ack) begin
                        pix_valid <= 1'b1;
                        pix_col   <= col;
                        pix_row   <= row;
                        line_end  <= last_col;
                        addr      <= addr + ADDR_W'(1);
                        col       <= last_col ? '0 : col + DIM_W'(1);
                        row       <= last_col ? row + DIM_W'(1) : row;
                        if (last_col && last_row) begin
                            state      <= DONE;
                            req        <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i_raster_scan_ctrl.sv
// tb_i_raster_scan_ctrl: randomized raster scans checked against a frame-order reference model
module tb_i_raster_scan_ctrl;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] img_width = '0;
    logic [12:0] img_height = '0;
    logic [25:0] base_addr = '0;
    logic        pix_valid, line_end, frame_done, busy, cfg_err;
    logic [12:0] pix_col, pix_row;
    int          errors = 0;
    int          checks = 0;
    i_raster_scan_ctrl_if #(.ADDR_W(26)) mif ();
    i_raster_scan_ctrl #(.DIM_W(13), .ADDR_W(26)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .img_width(img_width), .img_height(img_height), .base_addr(base_addr),
        .mem(mif), .pix_valid(pix_valid), .pix_col(pix_col), .pix_row(pix_row),
        .line_end(line_end), .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
    );
    always #5 clk = ~clk;
    typedef struct {
        int          w, h;
        logic [25:0] base;
        int          pct, sidx, slen, restart;
    } frame_t;
    logic [25:0] ack_addr[$];
    logic [12:0] pv_row[$], pv_col[$];
    bit          pv_le[$];
    int fd_cnt, fd_idx, fd_cyc, idle_cyc, abort_cyc, addr_changes, req_bad, first_ack, last_ack;
    bit timed_out, req_at_idle;
    // Drives one frame and records what the DUT produced; the test tasks judge it.
    task automatic run_scan(input int w, h, input logic [25:0] base, input int pct, sidx, slen, abort_after, restart_at);
        int acks, cyc, stall_cnt, bound;
        bit aborted, prev_stall;
        logic [25:0] prev_addr;
        ack_addr.delete(); pv_row.delete(); pv_col.delete(); pv_le.delete();
        fd_cnt = 0; fd_idx = -1; fd_cyc = -1; idle_cyc = -1; abort_cyc = -1;
        addr_changes = 0; req_bad = 0; first_ack = -1; last_ack = -1;
        timed_out = 0; req_at_idle = 0;
        acks = 0; stall_cnt = 0; aborted = 0; prev_stall = 0; prev_addr = '0;
        bound = w * h * 8 + slen + 40;
        @(negedge clk);
        img_width = 13'(w); img_height = 13'(h); base_addr = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        img_width = 13'($urandom); img_height = 13'($urandom); base_addr = 26'($urandom);
        cyc = 0;
        forever begin
            if (pix_valid) begin
                pv_row.push_back(pix_row); pv_col.push_back(pix_col); pv_le.push_back(line_end);
            end
            if (frame_done) begin
                fd_cnt++; fd_cyc = cyc;
                fd_idx = pix_valid ? pv_row.size() : -1;
                if (mif.mem_req) req_bad++;
            end
            if (prev_stall && mif.mem_req && mif.mem_addr !== prev_addr) addr_changes++;
            if (mif.mem_req && !busy) req_bad++;
            if (!busy) begin
                idle_cyc = cyc; req_at_idle = mif.mem_req;
                break;
            end
            if (cyc >= bound) begin
                timed_out = 1;
                break;
            end
            abort = 1'b0; start = 1'b0;
            if (abort_after > 0 && !aborted && acks == abort_after) begin
                abort = 1'b1; aborted = 1; abort_cyc = cyc;
            end
            if (cyc == restart_at) begin
                start = 1'b1;
                img_width = 13'($urandom_range(1, 20)); img_height = 13'($urandom_range(1, 20));
            end
            if (acks == sidx && stall_cnt < slen) begin
                mif.mem_ack = 1'b0; stall_cnt++;
            end else mif.mem_ack = ($urandom_range(99) >= pct);
            prev_stall = mif.mem_req && !mif.mem_ack;
            prev_addr  = mif.mem_addr;
            if (mif.mem_req && mif.mem_ack && !abort) begin
                ack_addr.push_back(mif.mem_addr);
                if (first_ack < 0) first_ack = cyc;
                last_ack = cyc; acks++;
            end
            cyc++;
            @(negedge clk);
        end
        abort = 1'b0; start = 1'b0; mif.mem_ack = 1'b0;
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req: got %b expected 0", mif.mem_req); end
        checks++; if (mif.mem_addr !== 26'd0) begin errors++; $display("FAIL reset mem_addr: got %h expected 0", mif.mem_addr); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset pix_valid: got %b expected 0", pix_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if ({frame_done, cfg_err, line_end} !== 3'b0) begin errors++; $display("FAIL reset pulses: got %b expected 000", {frame_done, cfg_err, line_end}); end
        checks++; if ({pix_row, pix_col} !== 26'd0) begin errors++; $display("FAIL reset coords: got %h expected 0", {pix_row, pix_col}); end
        n_rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, mif.mem_req} !== 2'b0) begin errors++; $display("FAIL idle_after_reset: got busy,req=%b expected 00", {busy, mif.mem_req}); end
    endtask
    task automatic test_frames();
        frame_t tbl[$];
        frame_t f;
        int n, m, r, c, bad_pix, bad_addr;
        logic [25:0] e;
        tbl.push_back('{3, 2, 26'h100, 0, -1, 0, -1});
        tbl.push_back('{4, 1, 26'h200, 0, 1, 3, -1});
        tbl.push_back('{1, 5, 26'h40, 30, -1, 0, -1});
        tbl.push_back('{7, 1, 26'h0, 30, -1, 0, -1});
        tbl.push_back('{1, 1, 26'h3ffffff, 0, -1, 0, -1});
        tbl.push_back('{3, 2, 26'h3fffffe, 20, -1, 0, -1});
        tbl.push_back('{5, 4, 26'h1000, 25, -1, 0, 6});
        tbl.push_back('{8191, 2, 26'h123, 0, -1, 0, -1});
        repeat (6) tbl.push_back('{int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 26'($urandom),
                                  int'($urandom_range(0, 60)), -1, 0,
                                  $urandom_range(0, 1) ? int'($urandom_range(0, 30)) : -1});
        foreach (tbl[k]) begin
            f = tbl[k];
            run_scan(f.w, f.h, f.base, f.pct, f.sidx, f.slen, -1, f.restart);
            n = f.w * f.h;
            checks++; if (timed_out) begin errors++; $display("FAIL frame%0d timeout: no return to idle within budget", k); end
            checks++; if (pv_row.size() != n) begin errors++; $display("FAIL frame%0d pix_count: got %0d expected %0d", k, pv_row.size(), n); end
            checks++; if (ack_addr.size() != n) begin errors++; $display("FAIL frame%0d ack_count: got %0d expected %0d", k, ack_addr.size(), n); end
            bad_pix = 0; bad_addr = 0;
            m = pv_row.size() < ack_addr.size() ? pv_row.size() : ack_addr.size();
            for (int i = 0; i < m && i < n; i++) begin
                r = i / f.w; c = i % f.w;
                e = f.base + 26'(r * f.w + c);
                if (pv_row[i] !== 13'(r) || pv_col[i] !== 13'(c) || pv_le[i] !== bit'(c == f.w - 1)) begin
                    if (bad_pix == 0) $display("FAIL frame%0d pixel[%0d]: got (%0d,%0d,le=%b) expected (%0d,%0d,le=%b)",
                                               k, i, pv_row[i], pv_col[i], pv_le[i], r, c, c == f.w - 1);
                    bad_pix++;
                end
                if (ack_addr[i] !== e) begin
                    if (bad_addr == 0) $display("FAIL frame%0d addr[%0d]: got %h expected %h", k, i, ack_addr[i], e);
                    bad_addr++;
                end
            end
            checks++; if (bad_pix != 0) errors++;
            checks++; if (bad_addr != 0) errors++;
            checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame%0d frame_done_count: got %0d expected 1", k, fd_cnt); end
            checks++; if (fd_idx != n) begin errors++; $display("FAIL frame%0d frame_done_with_last: got %0d expected %0d", k, fd_idx, n); end
            checks++; if (idle_cyc != fd_cyc + 1) begin errors++; $display("FAIL frame%0d busy_drop: got cycle %0d expected %0d", k, idle_cyc, fd_cyc + 1); end
            checks++; if (addr_changes != 0) begin errors++; $display("FAIL frame%0d addr_stable_in_stall: got %0d changes expected 0", k, addr_changes); end
            checks++; if (req_bad != 0) begin errors++; $display("FAIL frame%0d req_outside_scan: got %0d expected 0", k, req_bad); end
            if (f.pct == 0) begin
                checks++;
                if (last_ack - first_ack != n - 1 + f.slen) begin
                    errors++; $display("FAIL frame%0d ack_span: got %0d expected %0d", k, last_ack - first_ack, n - 1 + f.slen);
                end
            end
        end
    endtask
    task automatic test_cfg_err();
        int dims[3][2] = '{'{0, 5}, '{5, 0}, '{0, 0}};
        foreach (dims[k]) begin
            @(negedge clk);
            img_width = 13'(dims[k][0]); img_height = 13'(dims[k][1]); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err%0d pulse: got %b expected 1", k, cfg_err); end
            checks++; if ({busy, mif.mem_req} !== 2'b0) begin errors++; $display("FAIL cfg_err%0d idle: got busy,req=%b expected 00", k, {busy, mif.mem_req}); end
            @(negedge clk);
            checks++; if ({cfg_err, busy, mif.mem_req} !== 3'b0) begin errors++; $display("FAIL cfg_err%0d after: got %b expected 000", k, {cfg_err, busy, mif.mem_req}); end
        end
    endtask
    task automatic test_abort();
        int bad;
        run_scan(10, 10, 26'($urandom), 0, -1, 0, 17, -1);
        checks++; if (pv_row.size() != 17) begin errors++; $display("FAIL abort pix_count: got %0d expected 17", pv_row.size()); end
        bad = 0;
        for (int i = 0; i < pv_row.size() && i < 17; i++)
            if (pv_row[i] !== 13'(i / 10) || pv_col[i] !== 13'(i % 10)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL abort coords: got %0d wrong expected 0", bad); end
        checks++; if (fd_cnt != 0) begin errors++; $display("FAIL abort frame_done: got %0d expected 0", fd_cnt); end
        checks++; if (idle_cyc != abort_cyc + 1 || req_at_idle !== 1'b0) begin
            errors++; $display("FAIL abort req_drop: got idle at %0d req=%b expected %0d req=0", idle_cyc, req_at_idle, abort_cyc + 1);
        end
        @(negedge clk);
        img_width = 13'd4; img_height = 13'd4; base_addr = 26'h50; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mif.mem_ack = 1'b1; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; mif.mem_ack = 1'b0;
        checks++; if ({pix_valid, mif.mem_req, busy} !== 3'b0) begin errors++; $display("FAIL abort_with_ack: got valid,req,busy=%b expected 000", {pix_valid, mif.mem_req, busy}); end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if ({busy, mif.mem_req, cfg_err} !== 3'b0) begin errors++; $display("FAIL abort_with_start: got busy,req,cfg_err=%b expected 000", {busy, mif.mem_req, cfg_err}); end
        run_scan(6, 3, 26'h777, 20, -1, 0, -1, -1);
        checks++; if (pv_row.size() != 18 || fd_cnt != 1) begin errors++; $display("FAIL abort_restart count: got %0d pixels %0d done expected 18 1", pv_row.size(), fd_cnt); end
        checks++; if (ack_addr.size() == 0 || ack_addr[0] !== 26'h777 || pv_row[0] !== 13'd0 || pv_col[0] !== 13'd0) begin
            errors++; $display("FAIL abort_restart origin: got first addr %h expected 777 at (0,0)", ack_addr.size() ? ack_addr[0] : 26'h0);
        end
    endtask
    task automatic test_reset_mid_scan();
        @(negedge clk);
        img_width = 13'd6; img_height = 13'd6; base_addr = 26'h999; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mif.mem_ack = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if ({pix_valid, busy} !== 2'b11) begin errors++; $display("FAIL mid_scan_active: got valid,busy=%b expected 11", {pix_valid, busy}); end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({mif.mem_req, mif.mem_addr, pix_valid, pix_col, pix_row, line_end, frame_done, busy, cfg_err} !== 58'd0) begin
            errors++; $display("FAIL mid_scan_reset: got req=%b addr=%h valid=%b col=%0d row=%0d busy=%b expected all 0",
                               mif.mem_req, mif.mem_addr, pix_valid, pix_col, pix_row, busy);
        end
        @(negedge clk);
        n_rst = 1'b1; mif.mem_ack = 1'b0;
        run_scan(2, 2, 26'h10, 0, -1, 0, -1, -1);
        checks++; if (pv_row.size() != 4 || ack_addr.size() == 0 || ack_addr[0] !== 26'h10) begin
            errors++; $display("FAIL post_reset_frame: got %0d pixels expected 4 from addr 10", pv_row.size());
        end
    endtask
    initial begin
        mif.mem_ack = 1'b0;
        test_reset();
        test_frames();
        test_cfg_err();
        test_abort();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end
endmodule
